// File: rtl/candy_if.sv
//============================================================================
// Module   : candy_if
// Purpose  : Instruction fetch unit for the candy core. Single-outstanding
//            memory reads, registered decode output, one-entry skid buffer.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module candy_if #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_enable,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [23:0]       imem_rdata,
  output logic [23:0]       inst,
  output logic [ADDR_W-1:0] pc_out,
  output logic              id_enable,
  input  logic              id_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int c_INST_W = 24;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state,   w_state_nxt;
  logic [ADDR_W-1:0]   r_pc,      w_pc_nxt;
  logic [ADDR_W-1:0]   r_target,  w_target_nxt;
  logic [ADDR_W-1:0]   r_pc_out,  w_pc_out_nxt;
  logic [ADDR_W-1:0]   r_skid_pc, w_skid_pc_nxt;
  logic [c_INST_W-1:0] r_inst,    w_inst_nxt;
  logic [c_INST_W-1:0] r_skid,    w_skid_nxt;
  logic                r_valid,   w_valid_nxt;
  logic                r_pending;
  logic                w_req;
  logic                w_xfer;
  logic                w_slot_free;

  assign w_xfer      = r_valid & id_ready;
  assign w_slot_free = ~r_valid | id_ready;

  always_comb begin
    w_req = 1'b0;
    case (r_state)
      S_FETCH: w_req = if_enable | r_pending;
      S_HOLD:  w_req = 1'b0;
      S_DRAIN: w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
  end

  // Gated by reset so the request drops the instant reset asserts.
  assign imem_req  = rst & w_req;
  assign imem_addr = r_pc;
  assign inst      = r_inst;
  assign pc_out    = r_pc_out;
  assign id_enable = r_valid;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_target_nxt  = r_target;
    w_pc_out_nxt  = r_pc_out;
    w_skid_pc_nxt = r_skid_pc;
    w_inst_nxt    = r_inst;
    w_skid_nxt    = r_skid;
    w_valid_nxt   = r_valid;
    if (redirect) begin
      w_valid_nxt = 1'b0;
      // An issued request cannot be cancelled: let it finish in DRAIN.
      if (w_req && !imem_ack) begin
        w_state_nxt  = S_DRAIN;
        w_target_nxt = redirect_pc;
      end else begin
        w_state_nxt = S_FETCH;
        w_pc_nxt    = redirect_pc;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_req && imem_ack) begin
            if (w_slot_free) begin
              w_inst_nxt   = imem_rdata;
              w_pc_out_nxt = r_pc;
              w_valid_nxt  = 1'b1;
            end else begin
              w_skid_nxt    = imem_rdata;
              w_skid_pc_nxt = r_pc;
              w_state_nxt   = S_HOLD;
            end
            w_pc_nxt = r_pc + ADDR_W'(1);
          end else if (w_xfer) begin
            w_valid_nxt = 1'b0;
          end
        end
        S_HOLD: begin
          if (w_xfer) begin
            w_inst_nxt   = r_skid;
            w_pc_out_nxt = r_skid_pc;
            w_state_nxt  = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            w_pc_nxt    = r_target;
            w_state_nxt = S_FETCH;
          end
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_target  <= RESET_PC;
      r_pc_out  <= '0;
      r_skid_pc <= '0;
      r_inst    <= '0;
      r_skid    <= '0;
      r_valid   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_target  <= w_target_nxt;
      r_pc_out  <= w_pc_out_nxt;
      r_skid_pc <= w_skid_pc_nxt;
      r_inst    <= w_inst_nxt;
      r_skid    <= w_skid_nxt;
      r_valid   <= w_valid_nxt;
      r_pending <= w_req & ~imem_ack;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_candy_if.sv
//============================================================================
// Module   : tb_candy_if
// Purpose  : Self-checking bench for candy_if against an in-order program
//            stream model with a randomized-latency memory.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_candy_if;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_enable = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [23:0] imem_rdata = '0;
  logic [23:0] inst;
  logic [15:0] pc_out;
  logic        id_enable;
  logic        id_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;

  logic        req2, ide2;
  logic [15:0] addr2, pc_out2;
  logic [23:0] rdata2, inst2;

  function automatic logic [23:0] mem_word(input logic [15:0] a);
    logic [7:0] hi;
    hi = a[7:0] + 8'h02;
    return {hi, 16'h7890};
  endfunction

  candy_if #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .if_enable(if_enable),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst(inst), .pc_out(pc_out),
    .id_enable(id_enable), .id_ready(id_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  // Second instance with a wrapping reset PC and a zero-wait memory.
  assign rdata2 = mem_word(addr2);
  candy_if #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst(rst), .if_enable(if_enable),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(req2),
    .imem_rdata(rdata2), .inst(inst2), .pc_out(pc_out2),
    .id_enable(ide2), .id_ready(1'b1),
    .redirect(1'b0), .redirect_pc(16'h0000)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model and stream reference state
  int          mem_lat  = 0;
  bit          mem_rand = 0;
  bit          slow_en  = 0;
  logic [15:0] slow_addr = '0;
  int          slow_lat = 0;
  bit          req_active;
  int          wait_left;
  int          hold_cnt;
  bit          prev_hold;
  logic [15:0] prev_addr;
  logic [15:0] exp_pc;
  bit          cur_req;
  logic [15:0] cur_addr;
  int          n_xfer;
  int          n_ide;
  logic [15:0] req_log[$];
  logic [15:0] xfer_log[$];
  int          hold_log[$];

  task automatic clear_model();
    req_active = 0; wait_left = 0; hold_cnt = 0; prev_hold = 0;
    prev_addr = '0; exp_pc = 16'h0000; n_xfer = 0; n_ide = 0;
    req_log.delete(); xfer_log.delete(); hold_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0; if_enable = 1'b0; id_ready = 1'b0; redirect = 1'b0;
    imem_ack = 1'b0; mem_lat = 0; mem_rand = 0; slow_en = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_model();
  endtask

  // One clock cycle: drive inputs, act as memory, check protocol and stream.
  task automatic cycle(input logic en, input logic rdy, input logic redir,
                       input logic [15:0] rpc);
    bit exp_idle;
    @(negedge clk);
    if_enable = en; id_ready = rdy; redirect = redir; redirect_pc = rpc;
    #1;
    if (imem_req && !req_active) begin
      req_active = 1;
      hold_cnt   = 0;
      req_log.push_back(imem_addr);
      if (slow_en && imem_addr == slow_addr) wait_left = slow_lat;
      else if (mem_rand) wait_left = $urandom_range(0, 3);
      else wait_left = mem_lat;
    end
    imem_ack   = imem_req && (wait_left == 0);
    imem_rdata = imem_ack ? mem_word(imem_addr) : 24'($urandom);
    cur_req  = imem_req;
    cur_addr = imem_addr;
    if (prev_hold) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
        n_fail++;
        $display("FAIL req_stable: req=%b addr=%h, required req=1 addr=%h",
                 imem_req, imem_addr, prev_addr);
      end
    end
    #1;
    if (id_enable) n_ide++;
    if (id_enable && id_ready) begin
      n_checks++;
      if (pc_out !== exp_pc || inst !== mem_word(exp_pc)) begin
        n_fail++;
        $display("FAIL stream: pc_out=%h inst=%h, required pc_out=%h inst=%h",
                 pc_out, inst, exp_pc, mem_word(exp_pc));
      end
      xfer_log.push_back(pc_out);
      n_xfer++;
      exp_pc = exp_pc + 16'd1;
    end
    if (redir) exp_pc = rpc;
    exp_idle  = redir;
    prev_hold = imem_req && !imem_ack;
    prev_addr = imem_addr;
    if (imem_req) hold_cnt++;
    if (imem_ack) begin
      req_active = 0;
      hold_log.push_back(hold_cnt);
    end else if (imem_req) begin
      wait_left--;
    end
    @(posedge clk); #1;
    if (exp_idle) begin
      n_checks++;
      if (id_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL redirect_flush: id_enable=%b, required 0", id_enable);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; if_enable = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || inst !== 24'h0 ||
        pc_out !== 16'h0 || id_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: req=%b addr=%h inst=%h pc_out=%h ide=%b, required 0 0000 000000 0000 0",
               imem_req, imem_addr, inst, pc_out, id_enable);
    end
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (req_log.size() <= i || req_log[i] !== 16'(i)) begin
        n_fail++;
        $display("FAIL stream_addr[%0d]: got %h, required %h", i,
                 (req_log.size() > i) ? req_log[i] : 16'hxxxx, 16'(i));
      end
    end
    n_checks++;
    if (n_xfer !== 5) begin
      n_fail++;
      $display("FAIL stream_rate: %0d transfers in 6 cycles, required 5", n_xfer);
    end
  endtask

  task automatic test_wait();
    do_reset();
    mem_lat = 3;
    for (int i = 0; i < 13; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (hold_log.size() <= i || hold_log[i] !== 4) begin
        n_fail++;
        $display("FAIL wait_hold[%0d]: got %0d cycles, required 4", i,
                 (hold_log.size() > i) ? hold_log[i] : -1);
      end
    end
    n_checks++;
    if (n_ide !== 3 || xfer_log.size() !== 3) begin
      n_fail++;
      $display("FAIL wait_pulses: ide_cycles=%0d xfers=%0d, required 3 3",
               n_ide, xfer_log.size());
    end
  endtask

  task automatic test_stall();
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      if (i >= 1) begin
        n_checks++;
        if (cur_req !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_req[%0d]: imem_req=%b, required 0", i, cur_req);
        end
      end
    end
    n_checks++;
    if (inst !== mem_word(16'h0) || pc_out !== 16'h0 || id_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold: inst=%h pc_out=%h ide=%b, required %h 0000 1",
               inst, pc_out, id_enable, mem_word(16'h0));
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if (xfer_log.size() !== 3 || xfer_log[0] !== 16'd0 || xfer_log[1] !== 16'd1 ||
        xfer_log[2] !== 16'd2 || req_log[2] !== 16'd2) begin
      n_fail++;
      $display("FAIL stall_release: xfers=%0d, required 3 in order 0,1,2", xfer_log.size());
    end
  endtask

  task automatic test_redirect();
    do_reset();
    slow_en = 1; slow_addr = 16'h0005; slow_lat = 2;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b1, 16'h0040);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      n_checks++;
      if (cur_req !== 1'b1 || cur_addr !== 16'h0005) begin
        n_fail++;
        $display("FAIL drain_addr[%0d]: req=%b addr=%h, required 1 0005", i, cur_req, cur_addr);
      end
    end
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if (req_log.size() < 7 || req_log[5] !== 16'h0005 || req_log[6] !== 16'h0040) begin
      n_fail++;
      $display("FAIL redirect_req: next request %h, required 0040",
               (req_log.size() > 6) ? req_log[6] : 16'hxxxx);
    end
    n_checks++;
    if (xfer_log.size() < 6 || xfer_log[5] !== 16'h0040) begin
      n_fail++;
      $display("FAIL redirect_first: pc_out %h, required 0040",
               (xfer_log.size() > 5) ? xfer_log[5] : 16'hxxxx);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_seq[3];
    exp_seq[0] = 16'hFFFF; exp_seq[1] = 16'h0000; exp_seq[2] = 16'h0001;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      n_checks++;
      if (ide2 !== 1'b1 || pc_out2 !== exp_seq[i] || inst2 !== mem_word(exp_seq[i])) begin
        n_fail++;
        $display("FAIL wrap[%0d]: ide=%b pc_out=%h inst=%h, required 1 %h %h",
                 i, ide2, pc_out2, inst2, exp_seq[i], mem_word(exp_seq[i]));
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    if_enable = 1'b1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || inst !== 24'h0 ||
        pc_out !== 16'h0 || id_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: req=%b addr=%h inst=%h pc_out=%h ide=%b, required 0 0000 000000 0000 0",
               imem_req, imem_addr, inst, pc_out, id_enable);
    end
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if (req_log.size() < 1 || req_log[0] !== 16'h0000 ||
        xfer_log.size() < 1 || xfer_log[0] !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_restart: first request/transfer not at 0000 (reqs=%0d xfers=%0d)",
               req_log.size(), xfer_log.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    mem_rand = 1;
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, 16'($urandom_range(0, 511)));
    end
    n_checks++;
    if (n_xfer < 50) begin
      n_fail++;
      $display("FAIL random_progress: %0d transfers, required at least 50", n_xfer);
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
